seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It shares one hex-to-7-segment decoder among NUM_DIGITS digits and cycles the active-low anode selects. It inserts blanking dead-time between digits to suppress ghosting. New display values are applied only at frame boundaries through a load/ack handshake.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/hex_seg7_dec.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: active-low glyphs {a,b,c,d,e,f,g,dp}.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Element [n] is the glyph for hex digit n; dp left dark in every entry.
    localparam logic [15:0][7:0] SEG_GLYPH = {
        8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
        8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/hex_seg7_dec.sv
// Combinational hex nibble to active-low 7-segment glyph; dp bit always dark here.
module hex_seg7_dec
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [7:0] o_seg
);

    assign o_seg = SEG_GLYPH[i_nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with per-slot dead-time and frame-aligned loads.
// Define SEG7_LZS_EN to enable leading-zero suppression.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic                    load_ack,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam slot_state_t ST_RST = (DEAD_CYCLES > 0) ? ST_BLANK : ST_SHOW;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("seg7_scan_ctrl: NUM_DIGITS must be 1..8");
    end
    if (CLK_DIV < 4) begin : g_bad_div
        $error("seg7_scan_ctrl: CLK_DIV must be at least 4");
    end
    if (DEAD_CYCLES < 0 || DEAD_CYCLES >= CLK_DIV) begin : g_bad_dead
        $error("seg7_scan_ctrl: DEAD_CYCLES must be in 0..CLK_DIV-1");
    end

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    slot_state_t             r_state;
    logic [4*NUM_DIGITS-1:0] r_stage_data;
    logic [NUM_DIGITS-1:0]   r_stage_dp;
    logic [NUM_DIGITS-1:0]   r_stage_blank;
    logic                    r_pending;
    logic [4*NUM_DIGITS-1:0] r_shadow_data;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [NUM_DIGITS-1:0]   r_shadow_blank;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [7:0]              r_seg;
    logic                    r_load_ack;
    logic                    r_frame_done;

    logic                    w_cnt_wrap;
    logic                    w_boundary;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    slot_state_t             w_state_nxt;
    logic [3:0]              w_nib;
    logic                    w_dp_sel;
    logic                    w_blank_sel;
    logic                    w_dark;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic [7:0]              w_glyph;
    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic [7:0]              w_seg_nxt;

    always_comb begin
        w_cnt_wrap = (r_cnt == CNT_LAST);
        w_boundary = w_cnt_wrap && (r_idx == IDX_LAST);
        w_cnt_nxt  = w_cnt_wrap ? '0 : r_cnt + 1'b1;
        w_idx_nxt  = r_idx;
        if (w_cnt_wrap) begin
            w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    // Per-digit field select from the shadow (displayed) copy.
    always_comb begin
        w_nib       = '0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == r_idx) begin
                w_nib       = r_shadow_data[i*4 +: 4];
                w_dp_sel    = r_shadow_dp[i];
                w_blank_sel = r_shadow_blank[i];
            end
        end
    end

`ifdef SEG7_LZS_EN
    // A digit is suppressed while it and every digit above it are zero with dp dark.
    always_comb begin
        logic w_run;
        w_run = 1'b1;
        w_lz  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_run = w_run && (r_shadow_data[i*4 +: 4] == 4'h0) && !r_shadow_dp[i];
            w_lz[i] = w_run && (i != 0);
        end
    end
`else
    assign w_lz = '0;
`endif

    always_comb begin
        w_dark = w_blank_sel;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == r_idx && w_lz[i]) begin
                w_dark = 1'b1;
            end
        end
    end

    hex_seg7_dec u_dec (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = (w_cnt_nxt < CNT_DEAD) ? ST_BLANK : ST_SHOW;
        w_an_nxt    = '1;
        w_seg_nxt   = SEG_OFF;
        case (r_state)
            ST_SHOW: begin
                if (!w_dark) begin
                    w_an_nxt          = ~(NUM_DIGITS'(1) << r_idx);
                    w_seg_nxt         = w_glyph;
                    w_seg_nxt[SEG_DP] = ~w_dp_sel;
                end
            end
            default: begin
                w_an_nxt  = '1;
                w_seg_nxt = SEG_OFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_idx          <= '0;
            r_stage_data   <= '0;
            r_stage_dp     <= '0;
            r_stage_blank  <= '0;
            r_pending      <= 1'b0;
            r_shadow_data  <= '0;
            r_shadow_dp    <= '0;
            r_shadow_blank <= '0;
            r_an           <= '1;
            r_seg          <= SEG_OFF;
            r_load_ack     <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_frame_done <= w_boundary;
            r_load_ack   <= w_boundary && (r_pending || load);
            if (load) begin
                r_stage_data  <= digit_data;
                r_stage_dp    <= dp_mask;
                r_stage_blank <= blank_mask;
            end
            // A load landing on the boundary cycle bypasses staging straight to the shadow.
            if (w_boundary) begin
                r_pending <= 1'b0;
                if (load) begin
                    r_shadow_data  <= digit_data;
                    r_shadow_dp    <= dp_mask;
                    r_shadow_blank <= blank_mask;
                end else if (r_pending) begin
                    r_shadow_data  <= r_stage_data;
                    r_shadow_dp    <= r_stage_dp;
                    r_shadow_blank <= r_stage_blank;
                end
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign load_ack   = r_load_ack;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl against a slot/frame-level reference model.
module tb_seg7_scan_ctrl;

    localparam int N  = 4;
    localparam int CD = 8;
    localparam int DC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [4*N-1:0] digit_data;
    logic [N-1:0]  dp_mask;
    logic [N-1:0]  blank_mask;
    logic          load_ack;
    logic [N-1:0]  an;
    logic [7:0]    seg;
    logic          frame_done;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (N),
        .CLK_DIV     (CD),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .digit_data (digit_data),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .load_ack   (load_ack),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Segments lit for each hex digit, by letter name.
    string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [7:0] glyph(input int v, input bit dp);
        logic [7:0] g;
        g = 8'hFF;
        for (int i = 0; i < lit[v].len(); i++) begin
            int p;
            p = int'(lit[v][i]) - 97;
            g[7 - p] = 1'b0;
        end
        if (dp) g[0] = 1'b0;
        return g;
    endfunction

    // Reference state: cycles since reset plus displayed/staged copies.
    int   k;
    int   m_disp [N];
    bit   m_dp   [N];
    bit   m_bl   [N];
    int   s_disp [N];
    bit   s_dp   [N];
    bit   s_bl   [N];
    bit   m_pend;

    function automatic bit dark(input int d);
        bit lz;
        lz = 1'b0;
`ifdef SEG7_LZS_EN
        if (d != 0) begin
            lz = 1'b1;
            for (int j = d; j < N; j++)
                if (m_disp[j] != 0 || m_dp[j]) lz = 1'b0;
        end
`endif
        return m_bl[d] || lz;
    endfunction

    task automatic step();
        logic [N-1:0] e_an;
        logic [7:0]   e_seg;
        bit           e_ack, e_fd;
        if (rst) begin
            e_an = '1; e_seg = 8'hFF; e_ack = 0; e_fd = 0;
            k = 0; m_pend = 0;
            for (int i = 0; i < N; i++) begin
                m_disp[i] = 0; m_dp[i] = 0; m_bl[i] = 0;
                s_disp[i] = 0; s_dp[i] = 0; s_bl[i] = 0;
            end
        end else begin
            int  slot, d;
            bit  bnd;
            slot = k % CD;
            d    = (k / CD) % N;
            bnd  = (k % (CD * N)) == (CD * N - 1);
            if (slot < DC || dark(d)) begin
                e_an = '1; e_seg = 8'hFF;
            end else begin
                e_an = ~(N'(1) << d);
                e_seg = glyph(m_disp[d], m_dp[d]);
            end
            e_fd = bnd;
            if (load) begin
                for (int i = 0; i < N; i++) begin
                    s_disp[i] = int'(digit_data[i*4 +: 4]);
                    s_dp[i]   = dp_mask[i];
                    s_bl[i]   = blank_mask[i];
                end
                m_pend = 1;
            end
            e_ack = bnd && m_pend;
            if (bnd && m_pend) begin
                m_disp = s_disp; m_dp = s_dp; m_bl = s_bl;
                m_pend = 0;
            end
            k++;
        end
        @(posedge clk);
        #1;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("load_ack", 32'(load_ack), 32'(e_ack));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    // Advance until outputs reflect reference cycle 'target'.
    task automatic run_to(input int target);
        while (k <= target) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        load = 1; digit_data = d; dp_mask = dp; blank_mask = bl;
        step();
        load = 0; digit_data = $urandom; dp_mask = $urandom; blank_mask = $urandom;
    endtask

    initial begin
        rst = 1; load = 0; digit_data = '0; dp_mask = '0; blank_mask = '0;
        k = 0; m_pend = 0;
        step(); step();
        chk("rst_an", 32'(an), 32'h0000000F);
        chk("rst_seg", 32'(seg), 32'h000000FF);
        rst = 0;

        // Idle: digit 0 shows "0" after the dead-time.
        repeat (3) step();
        chk("idle_an", 32'(an), 32'h0000000E);
        chk("idle_seg", 32'(seg), 32'h00000003);
        run_to(40);

        run_to(44);
        do_load(16'h12AF, 4'b0010, 4'b0000);
        run_to(63);
        chk("ld_ack", 32'(load_ack), 32'd1);
        chk("ld_fd", 32'(frame_done), 32'd1);
        run_to(66);
        chk("ld_d0", 32'(seg), 32'h71);
        run_to(74);
        chk("ld_d1", 32'(seg), 32'h10);
        run_to(82);
        chk("ld_d2", 32'(seg), 32'h25);
        run_to(90);
        chk("ld_d3", 32'(seg), 32'h9F);

        // Two loads within one frame: last wins, single ack.
        run_to(99);
        do_load(16'h1111, 4'b0000, 4'b0000);
        run_to(110);
        do_load(16'h2222, 4'b0000, 4'b0000);
        run_to(130);
        chk("dbl_d0", 32'(seg), 32'h25);

        // Load exactly on the boundary cycle (k = 159).
        run_to(158);
        do_load(16'h3456, 4'b0000, 4'b0100);
        chk("bnd_ack", 32'(load_ack), 32'd1);
        run_to(162);
        chk("bnd_d0", 32'(seg), 32'h41);
        run_to(179);
        chk("bl_an", 32'(an), 32'h0000000F);
        chk("bl_seg", 32'(seg), 32'h000000FF);
        run_to(187);
        chk("bl_d3_an", 32'(an), 32'h00000007);

        // Reset during digit 2 SHOW with a load pending.
        run_to(195);
        do_load(16'h9999, 4'b1111, 4'b0000);
        run_to(211);
        rst = 1;
        step();
        chk("mid_rst_ack", 32'(load_ack), 32'd0);
        rst = 0;
        run_to(70);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            load       = ($urandom_range(0, 15) == 0);
            digit_data = $urandom;
            dp_mask    = $urandom;
            blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            rst        = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 0; load = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
